// File: rtl/io_port_ctrl_if.sv
// Stream side of the I/O port controller: source and sink channels.
// The master side is the external stream environment; the slave side is the controller.
interface io_port_ctrl_if #(
  parameter int NCH   = 4,
  parameter int NBIN  = 19,
  parameter int NBOUT = 28
);
  logic [NCH*NBIN-1:0]  src_data;
  logic [NCH-1:0]       src_valid;
  logic [NCH-1:0]       src_ready;
  logic [NCH*NBOUT-1:0] snk_data;
  logic [NCH-1:0]       snk_valid;
  logic [NCH-1:0]       snk_ready;

  modport master (
    output src_data, src_valid, snk_ready,
    input  src_ready, snk_data, snk_valid
  );

  modport slave (
    input  src_data, src_valid, snk_ready,
    output src_ready, snk_data, snk_valid
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Per-channel sample holding and output latching for the float processor I/O port.
// Define IOCTRL_ERRCNT_EN to build the saturating error-event counter.
module io_port_ctrl #(
  parameter int NCH   = 4,
  parameter int NBIN  = 19,
  parameter int NBOUT = 28
) (
  input  logic             clk,
  input  logic             rst,
  io_port_ctrl_if.slave    sio,
  input  logic [NCH-1:0]   req_in,
  output logic [NBIN-1:0]  proc_io_in,
  input  logic [NCH-1:0]   out_en,
  input  logic [NBOUT-1:0] proc_io_out,
  input  logic             clr_flags,
  output logic [NCH-1:0]   underrun,
  output logic [NCH-1:0]   overrun,
  output logic [15:0]      err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_e;

  hold_e                st_q [NCH];
  hold_e                st_d [NCH];
  logic [NBIN-1:0]      in_reg [NCH];
  logic [NBIN-1:0]      last_rd;
  logic [NCH-1:0]       in_full;
  logic [NCH-1:0]       cap;
  logic [NCH-1:0]       sel_oh;
  logic [NCH-1:0]       unr_ev;
  logic [NCH-1:0]       ovr_ev;
  logic [NCH*NBOUT-1:0] snk_q;
  logic [NCH-1:0]       vld_q;

  localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

  // Lowest requesting channel wins; others stay untouched.
  assign sel_oh = req_in & (~req_in + ONE);

  assign unr_ev = sel_oh & ~in_full;
  assign ovr_ev = out_en & vld_q & ~sio.snk_ready;

  assign sio.src_ready = ~in_full;
  assign sio.snk_data  = snk_q;
  assign sio.snk_valid = vld_q;

  // Zero-latency read mux, falls back to the last value read.
  always_comb begin
    proc_io_in = last_rd;
    for (int k = 0; k < NCH; k++) begin
      if (sel_oh[k] && in_full[k]) proc_io_in = in_reg[k];
    end
  end

  // Holding-register next state: capture when empty, release on read.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      st_d[k]    = st_q[k];
      cap[k]     = 1'b0;
      in_full[k] = (st_q[k] == FULL);
      unique case (st_q[k])
        EMPTY: begin
          if (sio.src_valid[k]) begin
            st_d[k] = FULL;
            cap[k]  = 1'b1;
          end
        end
        FULL: begin
          if (sel_oh[k]) st_d[k] = EMPTY;
        end
        default: st_d[k] = EMPTY;
      endcase
    end
  end

  // Holding-register state and sample storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= EMPTY;
        in_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k] <= st_d[k];
        if (cap[k]) in_reg[k] <= sio.src_data[k*NBIN +: NBIN];
      end
    end
  end

  // Remember what the processor saw on its last read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_rd <= '0;
    else if (|req_in) last_rd <= proc_io_in;
  end

  // Output registers: processor write loads, sink handshake drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snk_q <= '0;
      vld_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (out_en[k]) begin
          snk_q[k*NBOUT +: NBOUT] <= proc_io_out;
          vld_q[k]                <= 1'b1;
        end else if (vld_q[k] && sio.snk_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags; clear has priority over new events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= '0;
      overrun  <= '0;
    end else if (clr_flags) begin
      underrun <= '0;
      overrun  <= '0;
    end else begin
      underrun <= underrun | unr_ev;
      overrun  <= overrun | ovr_ev;
    end
  end

`ifdef IOCTRL_ERRCNT_EN
  logic [15:0] err_q;
  logic [15:0] ev_n;
  logic [16:0] ec_sum;

  // Count this cycle's events and form the unsaturated sum.
  always_comb begin
    ev_n = '0;
    for (int k = 0; k < NCH; k++) begin
      ev_n = ev_n + 16'(unr_ev[k]) + 16'(ovr_ev[k]);
    end
    ec_sum = {1'b0, err_q} + {1'b0, ev_n};
  end

  // Saturating event counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           err_q <= '0;
    else if (clr_flags) err_q <= '0;
    else if (ec_sum[16]) err_q <= 16'hFFFF;
    else                err_q <= ec_sum[15:0];
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Random + directed scoreboard bench for io_port_ctrl.
// Expected per-cycle outputs are queued by stimulus and popped by a monitor.
module tb_io_port_ctrl;

  localparam int NCH   = 4;
  localparam int NBIN  = 19;
  localparam int NBOUT = 28;

`ifdef IOCTRL_ERRCNT_EN
  localparam bit ECEN = 1'b1;
`else
  localparam bit ECEN = 1'b0;
`endif

  typedef struct {
    logic [NBIN-1:0]      pin;
    logic [NCH-1:0]       srdy;
    logic [NCH-1:0]       svld;
    logic [NCH*NBOUT-1:0] sdat;
    logic [NCH-1:0]       unr;
    logic [NCH-1:0]       ovr;
    logic [15:0]          ec;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   req_in;
  logic [NBIN-1:0]  proc_io_in;
  logic [NCH-1:0]   out_en;
  logic [NBOUT-1:0] proc_io_out;
  logic             clr_flags;
  logic [NCH-1:0]   underrun;
  logic [NCH-1:0]   overrun;
  logic [15:0]      err_cnt;

  io_port_ctrl_if #(.NCH(NCH), .NBIN(NBIN), .NBOUT(NBOUT)) bus ();

  io_port_ctrl #(.NCH(NCH), .NBIN(NBIN), .NBOUT(NBOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .sio         (bus.slave),
    .req_in      (req_in),
    .proc_io_in  (proc_io_in),
    .out_en      (out_en),
    .proc_io_out (proc_io_out),
    .clr_flags   (clr_flags),
    .underrun    (underrun),
    .overrun     (overrun),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit              m_full [NCH];
  logic [NBIN-1:0] m_hold [NCH];
  logic [NBIN-1:0] m_last;
  bit              m_val  [NCH];
  logic [NBOUT-1:0] m_dat [NCH];
  logic [NCH-1:0]  m_unr;
  logic [NCH-1:0]  m_ovr;
  int              m_ec;

  exp_t exp_q [$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_full[k] = 0;
      m_hold[k] = '0;
      m_val[k]  = 0;
      m_dat[k]  = '0;
    end
    m_last = '0;
    m_unr  = '0;
    m_ovr  = '0;
    m_ec   = 0;
  endtask

  // Apply inputs, queue this cycle's expected outputs, step the model.
  task automatic drive(input logic [NCH*NBIN-1:0] sd, input logic [NCH-1:0] sv,
                       input logic [NCH-1:0] rq, input logic [NCH-1:0] oe,
                       input logic [NBOUT-1:0] po, input logic [NCH-1:0] sr,
                       input logic cl);
    exp_t e;
    int   sel;
    int   nev;
    bus.src_data  = sd;
    bus.src_valid = sv;
    bus.snk_ready = sr;
    req_in        = rq;
    out_en        = oe;
    proc_io_out   = po;
    clr_flags     = cl;
    sel = -1;
    for (int k = NCH - 1; k >= 0; k--) if (rq[k]) sel = k;
    e.pin = (sel >= 0 && m_full[sel]) ? m_hold[sel] : m_last;
    for (int k = 0; k < NCH; k++) begin
      e.srdy[k] = !m_full[k];
      e.svld[k] = m_val[k];
      e.sdat[k*NBOUT +: NBOUT] = m_dat[k];
    end
    e.unr = m_unr;
    e.ovr = m_ovr;
    e.ec  = 16'(m_ec);
    exp_q.push_back(e);
    nev = 0;
    if (sel >= 0 && !m_full[sel]) begin
      nev++;
      m_unr[sel] = 1'b1;
    end
    for (int k = 0; k < NCH; k++) begin
      if (m_full[k]) begin
        if (k == sel) m_full[k] = 0;
      end else if (sv[k]) begin
        m_full[k] = 1;
        m_hold[k] = sd[k*NBIN +: NBIN];
      end
    end
    if (sel >= 0) m_last = e.pin;
    for (int k = 0; k < NCH; k++) begin
      if (oe[k]) begin
        if (m_val[k] && !sr[k]) begin
          nev++;
          m_ovr[k] = 1'b1;
        end
        m_dat[k] = po;
        m_val[k] = 1;
      end else if (m_val[k] && sr[k]) begin
        m_val[k] = 0;
      end
    end
    if (ECEN) m_ec = (m_ec + nev > 65535) ? 65535 : m_ec + nev;
    if (cl) begin
      m_unr = '0;
      m_ovr = '0;
      m_ec  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic reset_checks();
    chk("rst_src_ready", 128'(bus.src_ready), 128'hF);
    chk("rst_snk_valid", 128'(bus.snk_valid), 128'h0);
    chk("rst_snk_data", 128'(bus.snk_data), 128'h0);
    chk("rst_underrun", 128'(underrun), 128'h0);
    chk("rst_overrun", 128'(overrun), 128'h0);
    chk("rst_err_cnt", 128'(err_cnt), 128'h0);
    chk("rst_proc_io_in", 128'(proc_io_in), 128'h0);
  endtask

  task automatic rand_cycle();
    logic [95:0]      r96;
    logic [NCH-1:0]   rq;
    logic [NCH-1:0]   oe;
    int               r;
    r96 = {$urandom, $urandom, $urandom};
    r = $urandom_range(0, 7);
    if (r < 3)      rq = '0;
    else if (r < 6) rq = NCH'(1) << $urandom_range(0, NCH - 1);
    else            rq = NCH'($urandom);
    oe = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
    drive(r96[NCH*NBIN-1:0], NCH'($urandom), rq, oe, NBOUT'($urandom),
          NCH'($urandom), ($urandom_range(0, 31) == 0));
    tick();
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("proc_io_in", 128'(proc_io_in), 128'(e.pin));
      chk("src_ready", 128'(bus.src_ready), 128'(e.srdy));
      chk("snk_valid", 128'(bus.snk_valid), 128'(e.svld));
      chk("snk_data", 128'(bus.snk_data), 128'(e.sdat));
      chk("underrun", 128'(underrun), 128'(e.unr));
      chk("overrun", 128'(overrun), 128'(e.ovr));
      chk("err_cnt", 128'(err_cnt), 128'(e.ec));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*NBIN-1:0] sd;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.snk_ready = '0;
    req_in      = '0;
    out_en      = '0;
    proc_io_out = '0;
    clr_flags   = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    #1 reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Full read of ch2 holding -5
    sd = '0;
    sd[2*NBIN +: NBIN] = 19'h7FFFB;
    drive(sd, 4'b0100, '0, '0, '0, '0, 1'b0);
    tick();
    drive('0, '0, 4'b0100, '0, '0, '0, 1'b0);
    #1 chk("t2_proc_io_in", 128'(proc_io_in), 128'h7FFFB);
    tick();
    chk("t2_src_ready2", 128'(bus.src_ready[2]), 128'h1);
    chk("t2_underrun", 128'(underrun), 128'h0);

    // Underrun on empty ch0 returns the last read
    drive('0, '0, 4'b0001, '0, '0, '0, 1'b0);
    #1 chk("t3_proc_io_in", 128'(proc_io_in), 128'h7FFFB);
    tick();
    chk("t3_underrun", 128'(underrun), 128'h1);
    chk("t3_err_cnt", 128'(err_cnt), ECEN ? 128'h1 : 128'h0);

    // Write then overwrite unread ch3
    drive('0, '0, '0, 4'b1000, 28'h0ABCDEF, '0, 1'b0);
    tick();
    chk("t4_snk_valid3", 128'(bus.snk_valid[3]), 128'h1);
    chk("t4_snk_data3", 128'(bus.snk_data[3*NBOUT +: NBOUT]), 128'h0ABCDEF);
    chk("t4_overrun_pre", 128'(overrun), 128'h0);
    drive('0, '0, '0, 4'b1000, 28'h1, '0, 1'b0);
    tick();
    chk("t4_snk_data3b", 128'(bus.snk_data[3*NBOUT +: NBOUT]), 128'h1);
    chk("t4_overrun3", 128'(overrun), 128'h8);

    // Write on the same cycle as a handshake is not an overrun
    drive('0, '0, '0, 4'b0010, 28'h1234567, '0, 1'b0);
    tick();
    drive('0, '0, '0, 4'b0010, 28'h7654321, 4'b0010, 1'b0);
    tick();
    chk("t5_snk_valid1", 128'(bus.snk_valid[1]), 128'h1);
    chk("t5_snk_data1", 128'(bus.snk_data[1*NBOUT +: NBOUT]), 128'h7654321);
    chk("t5_overrun1", 128'(overrun[1]), 128'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) rand_cycle();

    // Asynchronous reset in the middle of traffic
    req_in = '0;
    rst = 1'b0;
    #1 reset_checks();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 1500; i++) rand_cycle();

    // Saturate the error counter: 1 underrun + 4 overruns per cycle
    drive('0, '0, '0, '0, '0, '0, 1'b1);
    tick();
    for (int i = 0; i < 13200; i++) begin
      drive('0, '0, 4'b0001, 4'b1111, NBOUT'($urandom), '0, 1'b0);
      tick();
    end
    chk("t6_err_sat", 128'(err_cnt), ECEN ? 128'hFFFF : 128'h0);
    chk("t6_flags_set", 128'({underrun, overrun}), 128'h1F);
    drive('0, '0, 4'b0001, 4'b1111, '0, '0, 1'b1);
    tick();
    chk("t6_clr_unr", 128'(underrun), 128'h0);
    chk("t6_clr_ovr", 128'(overrun), 128'h0);
    chk("t6_clr_ec", 128'(err_cnt), 128'h0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
